// File: rtl/mem_byte_lane_unit_pkg.sv
// mem_byte_lane_unit_pkg: size and state encodings, default timeout, alignment rule
package mem_byte_lane_unit_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
  typedef enum logic [1:0] {IDLE = 2'b00, ACCESS = 2'b01, DONE = 2'b10} state_e;
  localparam int TIMEOUT_CYCLES_DEFAULT = 16;
  function automatic logic misaligned(input size_e size, input logic [1:0] lo);
    return size == SZ_RSVD || (size == SZ_HALF && lo[0]) || (size == SZ_WORD && lo != 2'b00);
  endfunction
endpackage

// File: rtl/mem_byte_lane_unit_lane_select.sv
// lane_select: store byte enables and lane replication, load byte and halfword lane pick
module lane_select
  import mem_byte_lane_unit_pkg::*;
(
  input  size_e       size,
  input  logic        write,
  input  logic [1:0]  lo,
  input  logic [31:0] sdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [7:0]  byte_lane,
  output logic [15:0] half_lane
);
  always_comb begin
    be = !write ? 4'b0000 : size == SZ_BYTE ? 4'b0001 << lo : size == SZ_HALF ? 4'b0011 << lo : 4'b1111;
    wdata = size == SZ_BYTE ? {4{sdata[7:0]}} : size == SZ_HALF ? {2{sdata[15:0]}} : sdata;
    byte_lane = rdata[{lo, 3'b000} +: 8];
    half_lane = lo[1] ? rdata[31:16] : rdata[15:0];
  end
endmodule

// File: rtl/mem_byte_lane_unit.sv
// mem_byte_lane_unit: sub-word load/store sequencer onto a word memory port with ack timeout
module mem_byte_lane_unit
  import mem_byte_lane_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Write,
  input  logic [1:0]  Size,
  input  logic        Signed,
  input  logic [31:0] Addr,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [7:0]  ByteOut,
  output logic [15:0] HalfOut,
  output logic [31:0] WordOut,
  output logic        SignedOut,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBe,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  state_e state_q, state_d;
  size_e size_q, size_d;
  logic we_q, we_d, sgn_q, sgn_d, err_q, err_d, pend_q, pend_d;
  logic [31:0] addr_q, addr_d, sdata_q, sdata_d, word_q, word_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0] byte_q, byte_d, byte_lane;
  logic [15:0] half_q, half_d, half_lane;
  lane_select u_lane (
    .size(size_q),
    .write(we_q),
    .lo(addr_q[1:0]),
    .sdata(sdata_q),
    .rdata(MemRData),
    .be(MemBe),
    .wdata(MemWData),
    .byte_lane(byte_lane),
    .half_lane(half_lane)
  );
  always_comb begin
    state_d = state_q;
    size_d = size_q;
    we_d = we_q;
    sgn_d = sgn_q;
    err_d = err_q;
    pend_d = pend_q;
    addr_d = addr_q;
    sdata_d = sdata_q;
    cnt_d = cnt_q;
    byte_d = byte_q;
    half_d = half_q;
    word_d = word_q;
    if (state_q == IDLE && Start) begin
      we_d = Write;
      size_d = size_e'(Size);
      sgn_d = Signed;
      addr_d = Addr;
      sdata_d = StoreData;
      err_d = misaligned(size_e'(Size), Addr[1:0]);
      pend_d = err_d;
      cnt_d = '0;
      state_d = err_d ? DONE : ACCESS;
    end
    if (state_q == ACCESS) begin
      cnt_d = cnt_q + 1'b1;
      if (MemAck) begin
        state_d = DONE;
        byte_d = we_q ? byte_q : byte_lane;
        half_d = we_q ? half_q : half_lane;
        word_d = we_q ? word_q : MemRData;
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d = DONE;
        err_d = 1'b1;
      end
    end
    if (state_q == DONE) begin
      pend_d = 1'b0;
      state_d = pend_q ? DONE : IDLE;
    end
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      size_q <= SZ_BYTE;
      we_q <= 1'b0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      pend_q <= 1'b0;
      addr_q <= '0;
      sdata_q <= '0;
      cnt_q <= '0;
      byte_q <= '0;
      half_q <= '0;
      word_q <= '0;
    end else begin
      state_q <= state_d;
      size_q <= size_d;
      we_q <= we_d;
      sgn_q <= sgn_d;
      err_q <= err_d;
      pend_q <= pend_d;
      addr_q <= addr_d;
      sdata_q <= sdata_d;
      cnt_q <= cnt_d;
      byte_q <= byte_d;
      half_q <= half_d;
      word_q <= word_d;
    end
  end
  always_comb begin
    Busy = state_q != IDLE;
    Done = state_q == DONE && !pend_q;
    Error = Done && err_q;
    MemReq = state_q == ACCESS;
    MemWe = MemReq && we_q;
    MemAddr = {addr_q[31:2], 2'b00};
    ByteOut = byte_q;
    HalfOut = half_q;
    WordOut = word_q;
    SignedOut = sgn_q;
  end
endmodule
